// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtraction controller.
//   state_e       : controller FSM state encoding (IDLE, RUN, DONE)
//   DEF_WIDTH     : default operand/result width
package sub_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : sub_pkg

// File: rtl/full_subtractor.sv
// Gate-level one-bit full subtractor: computes a - b - carry_in.
//   sub      : difference bit
//   borrow   : borrow out, 1 when a < b + carry_in
//   a, b     : operand bits
//   carry_in : borrow in
module full_subtractor (
  output logic sub,
  output logic borrow,
  input  logic a,
  input  logic b,
  input  logic carry_in
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign sub     = a_xor_b ^ carry_in;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign borrow  = (~a & b) | (~a_xor_b & carry_in);

endmodule : full_subtractor

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction controller. Shares one full_subtractor across a
// WIDTH-bit operand pair, producing a_in - b_in - bin LSB-first, one bit
// per clock, with a registered borrow chaining each bit into the next.
//   clk, rst_n  : clock (rising edge), synchronous active-low reset
//   start       : request, honoured only in IDLE or DONE
//   a_in, b_in  : minuend / subtrahend, captured on accepted start
//   bin         : initial borrow-in, captured on accepted start
//   busy        : high while bits are being processed
//   done        : one-cycle pulse when diff/borrow_out are final
//   diff        : (a_in - b_in - bin) mod 2^WIDTH, valid from done onward
//   borrow_out  : 1 iff a_in < b_in + bin (unsigned)
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   diff_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               borrow_q;
  logic               borrow_out_q;
  logic               busy_q;
  logic               done_q;

  logic               sub_bit;
  logic               borrow_bit;

  full_subtractor u_fs (
    .sub      (sub_bit),
    .borrow   (borrow_bit),
    .a        (a_sh_q[0]),
    .b        (b_sh_q[0]),
    .carry_in (borrow_q)
  );

  // NOTE: every register here is written with <= so all updates take the
  // values from before the edge; blocking = would let later statements see
  // half-updated state and break the shift chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        // DONE accepts start exactly like IDLE, so back-to-back requests
        // run with no idle bubble.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q   <= a_in;
            b_sh_q   <= b_in;
            borrow_q <= bin;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end

        RUN: begin
          // LSB-first result enters at the top; after WIDTH shifts the
          // first bit computed has reached bit 0.
          diff_q   <= {sub_bit, diff_q[WIDTH-1:1]};
          borrow_q <= borrow_bit;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          if (cnt_q == LAST_BIT) begin
            borrow_out_q <= borrow_bit;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule : serial_sub_ctrl

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8): directed cases plus
// randomized operations compared against an arithmetic reference model.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int n_vec;
  int n_err;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic logic [W-1:0] ref_diff(input int a, input int b, input int bi);
    int r;
    r = a - b - bi;
    if (r < 0) r += (1 << W);
    return W'(r);
  endfunction

  function automatic logic ref_borrow(input int a, input int b, input int bi);
    return a < (b + bi);
  endfunction

  // Checks the W busy cycles after an accepted start; current time is the
  // negedge right after the accepting edge. Optionally jitters start with
  // junk operands while busy (must be ignored). Leaves us at the done cycle.
  task automatic watch_busy(input bit noise);
    for (int i = 1; i <= W; i++) begin
      check("busy_run", busy, 1'b1);
      check("done_run", done, 1'b0);
      if (noise && i < W) begin
        start = 1'($urandom_range(0, 1));
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        bin   = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_result(input int a, input int b, input int bi);
    check("done_pulse", done, 1'b1);
    check("busy_done", busy, 1'b0);
    check("diff", diff, ref_diff(a, b, bi));
    check("borrow_out", borrow_out, ref_borrow(a, b, bi));
  endtask

  // Full operation: request, W busy cycles, done cycle, one hold cycle.
  task automatic op(input int a, input int b, input int bi, input bit noise);
    a_in = W'(a); b_in = W'(b); bin = 1'(bi); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    watch_busy(noise);
    check_result(a, b, bi);
    @(negedge clk);
    check("done_once", done, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("diff_hold", diff, ref_diff(a, b, bi));
    check("borrow_hold", borrow_out, ref_borrow(a, b, bi));
  endtask

  initial begin
    int a, b, bi;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 8'h00);
    check("rst_borrow", borrow_out, 1'b0);
    rst_n = 1'b1;

    // Directed cases.
    op(200, 55, 0, 1'b0);
    op(5, 9, 0, 1'b0);
    op(0, 0, 1, 1'b0);
    op(255, 255, 0, 1'b0);
    // Start while busy is ignored; noise drives junk a=1,b=1 pulses.
    a_in = 8'd100; b_in = 8'd30; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b1; a_in = 8'd1; b_in = 8'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 2; i <= W; i++) begin
      check("busy_ign", busy, 1'b1);
      check("done_ign", done, 1'b0);
      @(negedge clk);
    end
    check_result(100, 30, 0);
    @(negedge clk);
    check("done_once_ign", done, 1'b0);

    // Back-to-back: new request held during the done cycle.
    a_in = 8'd50; b_in = 8'd20; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    watch_busy(1'b0);
    check_result(50, 20, 0);
    a_in = 8'd7; b_in = 8'd8; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    watch_busy(1'b0);
    check_result(7, 8, 0);
    @(negedge clk);

    // Reset mid-run aborts with no done pulse.
    a_in = 8'd77; b_in = 8'd11; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      check("busy_pre_rst", busy, 1'b1);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_diff", diff, 8'h00);
    check("abort_borrow", borrow_out, 1'b0);
    rst_n = 1'b1;
    op(12, 3, 0, 1'b0);
    repeat (W + 2) begin
      check("no_late_done", done, 1'b0);
      @(negedge clk);
    end

    // Randomized operations with random ignored starts while busy.
    for (int n = 0; n < 60; n++) begin
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      bi = int'($urandom_range(0, 1));
      if (n % 10 == 0) b = a;
      op(a, b, bi, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_serial_sub_ctrl
